// File: rtl/wb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// wb_fifo_uart_tx
//
// Pops words from a Wishbone-attached FIFO and transmits each one as an
// 8N1-style UART frame (start bit, DW data bits LSB first, stop bit).
//
// Optional feature macro: WB_FIFO_UART_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the data bits) is sent between
//   the last data bit and the stop bit.
//
// Ports:
//   i_clk           system clock
//   i_reset_n       synchronous active-low reset
//   o_wb_pop_stb    pop request strobe, one cycle wide
//   o_wb_pop_cyc    bus cycle, high from strobe until ack or timeout
//   i_wb_pop_data   popped word, valid while i_wb_pop_ack is high
//   i_wb_pop_ack    pop acknowledge
//   i_wb_pop_stall  responder stall; no strobe is issued while high
//   i_fifo_empty    FIFO empty flag
//   o_uart_tx       serial line, idle high
//   o_busy          high in every state except IDLE and GUARD
//   o_timeout_err   sticky ack-timeout flag, cleared only by reset
//
// Pop handshake: a request is offered by holding o_wb_pop_stb high for exactly
// one cycle together with o_wb_pop_cyc, and only when i_wb_pop_stall is low in
// IDLE. The word transfers in the cycle i_wb_pop_ack is high while the block
// waits for it; acks seen in any other state are ignored. If no ack arrives
// within ACK_TIMEOUT cycles of the strobe the cycle is dropped and the word is
// considered lost.
// -----------------------------------------------------------------------------
module wb_fifo_uart_tx #(
    parameter int DW           = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int ACK_TIMEOUT  = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    output logic          o_wb_pop_stb,
    output logic          o_wb_pop_cyc,
    input  logic [DW-1:0] i_wb_pop_data,
    input  logic          i_wb_pop_ack,
    input  logic          i_wb_pop_stall,
    input  logic          i_fifo_empty,
    output logic          o_uart_tx,
    output logic          o_busy,
    output logic          o_timeout_err
);

    localparam int GUARD_CYCLES = 2;
    localparam int GUARD_W      = $clog2(GUARD_CYCLES) + 1;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W        = $clog2(DW) + 1;
    localparam int TO_W         = $clog2(ACK_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_GUARD,
        S_IDLE,
        S_REQ,
        S_WAIT_ACK,
        S_START,
        S_DATA,
`ifdef WB_FIFO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              state, state_n;
    logic [GUARD_W-1:0]  guard_cnt, guard_n;
    logic [BAUD_W-1:0]   baud_cnt, baud_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [TO_W-1:0]     to_cnt, to_n;
    logic [DW-1:0]       shift_reg, shift_n;
    logic                err_n;
    logic                stb_n, cyc_n, tx_n, busy_n;
    logic                baud_end;
`ifdef WB_FIFO_UART_TX_PARITY_EN
    logic                parity_q, parity_n;
`endif

    assign baud_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    // Next-state and next-output logic. Outputs are derived from the next
    // state so that every output port comes straight from a flop.
    always_comb begin
        state_n   = state;
        guard_n   = guard_cnt;
        baud_n    = baud_cnt;
        bit_n     = bit_cnt;
        to_n      = to_cnt;
        shift_n   = shift_reg;
        err_n     = o_timeout_err;
`ifdef WB_FIFO_UART_TX_PARITY_EN
        parity_n  = parity_q;
`endif

        case (state)
            S_GUARD: begin
                // Lets the responder's empty flag and pointers settle after
                // the previous pop before it is sampled again.
                if (guard_cnt <= GUARD_W'(1)) begin
                    guard_n = '0;
                    state_n = S_IDLE;
                end else begin
                    guard_n = guard_cnt - 1'b1;
                end
            end
            S_IDLE: begin
                if (!i_fifo_empty && !i_wb_pop_stall) begin
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                // First WAIT_ACK cycle is one cycle after the strobe.
                to_n    = TO_W'(1);
                state_n = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (i_wb_pop_ack) begin
                    shift_n = i_wb_pop_data;
`ifdef WB_FIFO_UART_TX_PARITY_EN
                    parity_n = ^i_wb_pop_data;
`endif
                    to_n    = '0;
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_START;
                end else if (to_cnt >= TO_W'(ACK_TIMEOUT)) begin
                    to_n    = '0;
                    err_n   = 1'b1;
                    guard_n = GUARD_W'(GUARD_CYCLES);
                    state_n = S_GUARD;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_n  = '0;
                    shift_n = shift_reg >> 1;
                    if (bit_cnt == BIT_W'(DW - 1)) begin
                        bit_n = '0;
`ifdef WB_FIFO_UART_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`ifdef WB_FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_n  = '0;
                    state_n = S_STOP;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_n  = '0;
                    guard_n = GUARD_W'(GUARD_CYCLES);
                    state_n = S_GUARD;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                guard_n = GUARD_W'(GUARD_CYCLES);
                state_n = S_GUARD;
            end
        endcase

        stb_n  = (state_n == S_REQ);
        cyc_n  = (state_n == S_REQ) || (state_n == S_WAIT_ACK);
        busy_n = (state_n != S_GUARD) && (state_n != S_IDLE);

        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
`ifdef WB_FIFO_UART_TX_PARITY_EN
            S_PARITY: tx_n = parity_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state         <= S_GUARD;
            guard_cnt     <= GUARD_W'(GUARD_CYCLES);
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            to_cnt        <= '0;
            shift_reg     <= '0;
            o_timeout_err <= 1'b0;
            o_wb_pop_stb  <= 1'b0;
            o_wb_pop_cyc  <= 1'b0;
            o_uart_tx     <= 1'b1;
            o_busy        <= 1'b0;
`ifdef WB_FIFO_UART_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            guard_cnt     <= guard_n;
            baud_cnt      <= baud_n;
            bit_cnt       <= bit_n;
            to_cnt        <= to_n;
            shift_reg     <= shift_n;
            o_timeout_err <= err_n;
            o_wb_pop_stb  <= stb_n;
            o_wb_pop_cyc  <= cyc_n;
            o_uart_tx     <= tx_n;
            o_busy        <= busy_n;
`ifdef WB_FIFO_UART_TX_PARITY_EN
            parity_q      <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_wb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_wb_fifo_uart_tx
//
// Directed bench for wb_fifo_uart_tx. A small FIFO/Wishbone responder model
// acks each strobe two cycles later and pushes the handed-over word onto the
// expected queue; a UART line monitor pops it when a start bit appears and
// compares the whole frame cycle by cycle. Honours WB_FIFO_UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_fifo_uart_tx;

    localparam int DW          = 8;
    localparam int CPB         = 16;
    localparam int ACK_TIMEOUT = 8;
`ifdef WB_FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS  = DW + 3;
`else
    localparam int FRAME_BITS  = DW + 2;
`endif
    localparam int FRAME_CYC   = FRAME_BITS * CPB;

    // ---------------- clock / reset ----------------
    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          o_wb_pop_stb;
    logic          o_wb_pop_cyc;
    logic [DW-1:0] i_wb_pop_data = '0;
    logic          i_wb_pop_ack = 1'b0;
    logic          i_wb_pop_stall = 1'b0;
    logic          i_fifo_empty = 1'b1;
    logic          o_uart_tx;
    logic          o_busy;
    logic          o_timeout_err;

    always #5 i_clk = ~i_clk;

    wb_fifo_uart_tx #(
        .DW(DW),
        .CLKS_PER_BIT(CPB),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .o_wb_pop_stb(o_wb_pop_stb),
        .o_wb_pop_cyc(o_wb_pop_cyc),
        .i_wb_pop_data(i_wb_pop_data),
        .i_wb_pop_ack(i_wb_pop_ack),
        .i_wb_pop_stall(i_wb_pop_stall),
        .i_fifo_empty(i_fifo_empty),
        .o_uart_tx(o_uart_tx),
        .o_busy(o_busy),
        .o_timeout_err(o_timeout_err)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic ack_en = 1'b1;
    logic ack_pend = 1'b0;

    int stb_total = 0;
    int tx_low_total = 0;
    int busy_total = 0;
    int cyc_run = 0;
    int last_cyc_len = 0;
    logic prev_stb = 1'b0;
    logic prev_err = 1'b0;

    int frames_done = 0;
    int frames_started = 0;
    logic mon_active = 1'b0;
    int mon_pos = 0;
    int mon_bad = 0;
    logic [DW-1:0] mon_word_exp = '0;
    logic [FRAME_BITS-1:0] mon_bits = '1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [DW-1:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return w[idx-1];
`ifdef WB_FIFO_UART_TX_PARITY_EN
        if (idx == DW + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    task automatic wait_frames(input int target, input string tag);
        int n = 0;
        while (frames_done < target && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, frames_done >= target, 1);
    endtask

    // ---------------- driver: FIFO / Wishbone responder ----------------
    // Strobe seen at edge k+1 -> ack driven for the cycle after edge k+2,
    // i.e. two cycles after the strobe cycle.
    initial begin
        logic [DW-1:0] w;
        forever begin
            @(posedge i_clk);
            if (!i_reset_n) begin
                ack_pend = 1'b0;
                i_wb_pop_ack <= 1'b0;
            end else begin
                i_wb_pop_ack <= 1'b0;
                if (ack_pend) begin
                    ack_pend = 1'b0;
                    if (ack_en && fifo_q.size() > 0) begin
                        w = fifo_q.pop_front();
                        exp_q.push_back(w);
                        i_wb_pop_data <= w;
                        i_wb_pop_ack  <= 1'b1;
                    end
                end
                if (o_wb_pop_stb && ack_en) ack_pend = 1'b1;
            end
            i_fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // ---------------- protocol monitor ----------------
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_reset_n) begin
                if (o_wb_pop_stb) begin
                    stb_total++;
                    check("stb_adjacent", prev_stb, 0);
                    check("stb_without_cyc", o_wb_pop_cyc, 1);
                end
                if (o_wb_pop_cyc) begin
                    cyc_run++;
                end else if (cyc_run != 0) begin
                    last_cyc_len = cyc_run;
                    cyc_run = 0;
                end
                if (!o_uart_tx) tx_low_total++;
                if (o_busy) busy_total++;
                if (prev_err) check("err_sticky", o_timeout_err, 1);
                prev_stb = o_wb_pop_stb;
                prev_err = o_timeout_err;
            end else begin
                prev_stb = 1'b0;
                prev_err = 1'b0;
                cyc_run  = 0;
            end
        end
    end

    // ---------------- UART line monitor (scoreboard pop) ----------------
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                mon_active = 1'b0;
            end else if (mon_active) begin
                if (mon_pos < FRAME_CYC) begin
                    if (o_uart_tx !== exp_bit(mon_word_exp, mon_pos / CPB)) mon_bad++;
                    if (o_busy !== 1'b1) mon_bad++;
                    if (mon_pos % CPB == CPB / 2) mon_bits[mon_pos / CPB] = o_uart_tx;
                    mon_pos++;
                end else begin
                    // First cycle after the stop bit: frame must be over.
                    check("frame_shape", mon_bad, 0);
                    check("frame_data", mon_bits[DW:1], mon_word_exp);
                    check("frame_start_stop", {mon_bits[0], mon_bits[FRAME_BITS-1]}, 2'b01);
`ifdef WB_FIFO_UART_TX_PARITY_EN
                    check("frame_parity", mon_bits[DW+1], ^mon_word_exp);
`endif
                    check("frame_end_busy", o_busy, 0);
                    frames_done++;
                    mon_active = 1'b0;
                end
            end else if (o_uart_tx === 1'b0) begin
                frames_started++;
                check("frame_expected", exp_q.size() != 0, 1);
                mon_word_exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                mon_active = 1'b1;
                mon_bad    = (o_busy !== 1'b1) ? 1 : 0;
                mon_bits   = '1;
                mon_pos    = 1;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s_stb, s_tx, s_busy, s_fr, s_st, n;

        // Reset held two cycles.
        i_reset_n = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_stb", o_wb_pop_stb, 0);
        check("rst_cyc", o_wb_pop_cyc, 0);
        check("rst_tx", o_uart_tx, 1);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_timeout_err, 0);
        i_reset_n = 1'b1;

        // Empty FIFO for 100 cycles: nothing happens.
        s_stb = stb_total; s_tx = tx_low_total; s_busy = busy_total;
        repeat (100) @(negedge i_clk);
        check("idle_stb_count", stb_total - s_stb, 0);
        check("idle_tx_low", tx_low_total - s_tx, 0);
        check("idle_busy", busy_total - s_busy, 0);
        check("idle_err", o_timeout_err, 0);

        // Single word 0xA5.
        s_stb = stb_total; s_fr = frames_done;
        fifo_q.push_back(8'hA5);
        wait_frames(s_fr + 1, "a5_frame_wait");
        check("a5_stb_count", stb_total - s_stb, 1);

        // Back-to-back 0x01, 0xFF.
        s_stb = stb_total; s_fr = frames_done;
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'hFF);
        wait_frames(s_fr + 2, "b2b_frame_wait");
        check("b2b_stb_count", stb_total - s_stb, 2);

        // Stall holds off the strobe.
        i_wb_pop_stall = 1'b1;
        s_stb = stb_total; s_fr = frames_done;
        fifo_q.push_back(8'h5A);
        repeat (40) @(negedge i_clk);
        check("stall_stb_count", stb_total - s_stb, 0);
        check("stall_busy", o_busy, 0);
        i_wb_pop_stall = 1'b0;
        wait_frames(s_fr + 1, "stall_frame_wait");

        // Ack withheld: timeout, sticky error, no start bit.
        ack_en = 1'b0;
        s_tx = tx_low_total; s_st = frames_started; s_fr = frames_done;
        fifo_q.push_back(8'h3C);
        n = 0;
        while (o_timeout_err !== 1'b1 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("timeout_err_set", o_timeout_err, 1);
        @(negedge i_clk);
        check("timeout_cyc_low", o_wb_pop_cyc, 0);
        check("timeout_cyc_len", last_cyc_len, ACK_TIMEOUT + 1);
        check("timeout_no_start", tx_low_total - s_tx, 0);
        check("timeout_no_frame", frames_started - s_st, 0);
        ack_en = 1'b1;
        wait_frames(s_fr + 1, "retry_frame_wait");
        check("timeout_err_kept", o_timeout_err, 1);

        // Reset in the middle of data bit 3, with another word pending.
        s_fr = frames_done;
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h66);
        n = 0;
        while (!(mon_active && mon_pos >= 4 * CPB + CPB / 2) && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        check("midreset_reached_bit3", mon_active && mon_pos >= 4 * CPB + CPB / 2, 1);
        i_reset_n = 1'b0;
        @(negedge i_clk);
        check("midreset_tx", o_uart_tx, 1);
        check("midreset_busy", o_busy, 0);
        check("midreset_cyc", o_wb_pop_cyc, 0);
        check("midreset_stb", o_wb_pop_stb, 0);
        @(negedge i_clk);
        check("midreset_err_cleared", o_timeout_err, 0);
        i_reset_n = 1'b1;
        // Two guard cycles, one IDLE cycle, then the strobe.
        n = 0;
        while (o_wb_pop_stb !== 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check("midreset_guard_latency", n, 3);
        wait_frames(s_fr + 1, "midreset_frame_wait");

`ifdef WB_FIFO_UART_TX_PARITY_EN
        s_fr = frames_done;
        fifo_q.push_back(8'h07);
        fifo_q.push_back(8'h03);
        wait_frames(s_fr + 2, "parity_frame_wait");
`endif

        repeat (5) @(negedge i_clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("fifo_drained", fifo_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish within 100000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_fifo_uart_tx.md
Name: wb_fifo_uart_tx

Overview:
- Wishbone pop-side initiator that drains a wb_fifo instance and serialises each popped word onto an 8N1 UART line.
- Sits between the CPU-fed transmit FIFO and the board TX pin.
- Issues single-cycle pop strobes, waits for the ack with a timeout, then shifts the word out LSB first.

Parameters:
- DW, 8, word width popped from the FIFO and serialised (number of data bits).
- CLKS_PER_BIT, 16, i_clk cycles per UART bit; must be >= 4.
- ACK_TIMEOUT, 8, max cycles from strobe to ack before the transfer is abandoned; must be >= 3.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  reset.
- o_wb_pop_stb  out  1  pop request strobe, one cycle wide.
- o_wb_pop_cyc  out  1  bus cycle, high from strobe until ack or timeout.
- i_wb_pop_data  in  DW  popped word, valid in the cycle i_wb_pop_ack is high.
- i_wb_pop_ack  in  1  pop acknowledge.
- i_wb_pop_stall  in  1  responder stall; no strobe is issued while high.
- i_fifo_empty  in  1  FIFO empty flag.
- o_uart_tx  out  1  serial line, idle high.
- o_busy  out  1  high in every state except IDLE and GUARD.
- o_timeout_err  out  1  sticky; set on ack timeout, cleared only by reset.

Interface decision:
- One clock, i_clk.
- i_reset_n is synchronous and active-low.

Behaviour:
- Reset (i_reset_n low at a clock edge): state=GUARD, guard count 2, o_wb_pop_stb=0, o_wb_pop_cyc=0, o_uart_tx=1, o_busy=0, o_timeout_err=0, shift register=0, all counters=0.
- Reset mid-frame aborts immediately: line returns high, and the popped word is discarded.
- All outputs are registered.
- GUARD: wait 2 cycles (so the responder's empty and pointer state is settled), then go to IDLE.
- IDLE: if !i_fifo_empty && !i_wb_pop_stall, go to REQ; otherwise stay.
- REQ: drive stb=1 and cyc=1 for exactly one cycle, then go to WAIT_ACK.
  - stb is never high in two consecutive cycles.
  - stb is never high while cyc is low.
- WAIT_ACK: cyc=1, stb=0; a timeout counter counts cycles since the strobe.
  - On i_wb_pop_ack: latch i_wb_pop_data into the shift register, drop cyc, go to START. Nominal ack arrives 2 cycles after stb.
  - If the count reaches ACK_TIMEOUT without an ack: drop cyc, set o_timeout_err, go to GUARD. No frame is sent.
  - An ack arriving while in any state other than WAIT_ACK is ignored.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: DW bits, LSB first, each held CLKS_PER_BIT cycles. The bit counter runs 0..DW-1.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to GUARD.
  - The guard ensures i_fifo_empty reflects the completed pop before it is re-sampled.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, and resets on entry to START.
- Frame length: exactly (DW+2)*CLKS_PER_BIT cycles from the first tx=0 cycle to the end of the stop bit.
- Back-to-back words: the next start bit begins no sooner than GUARD(2) + REQ(1) + ack latency after the stop bit ends. The line stays high in between.
- i_fifo_empty or i_wb_pop_stall changing outside IDLE has no effect.
- Counter widths: $clog2 of each bound, plus 1 bit, so no overflow at the limits.

Optional Feature:
- Macro: WB_FIFO_UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the DW data bits) is inserted as a PARITY state between DATA and STOP, held CLKS_PER_BIT cycles. Frame length becomes (DW+3)*CLKS_PER_BIT.
- Undefined: no PARITY state exists; DATA goes straight to STOP.

Test Plan:
- Reset held 2 cycles, empty=1 for 100 cycles -> stb never asserted, tx=1 throughout, busy=0, err=0.
- FIFO holds 0xA5, ack 2 cycles after stb -> single one-cycle stb; tx sequence (each bit 16 cycles) is 0, then 1,0,1,0,0,1,0,1, then 1; total 160 cycles; busy high during the frame.
- FIFO holds 0x01 then 0xFF -> two frames, no overlap, stb pulses never adjacent, second frame bits 0,1×8,1.
- Ack withheld -> cyc drops after 8 cycles, err=1 and stays 1, no start bit; the next word (ack given) is transmitted normally with err still 1.
- Reset asserted in the middle of data bit 3 -> the next cycle has tx=1, busy=0, cyc=0; after 2 guard cycles a pending word is popped again.
- With WB_FIFO_UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1; send 0x03 -> parity bit=0; frame length 176 cycles.
